unified_mem_arbiter: RTL and testbench

- Shares one single-ported memory bus between the instruction-fetch (IF) stage and the load/store (MEM) stage of the pipelined RV32 core.
- Serialises transactions, holds bus signals stable until acknowledge, and returns read data with a one-cycle done pulse.
- Drives per-stage stall requests into the pipeline hazard/stall controller.
- Sits between the IF/MEM stage logic and the external memory.

---
 rtl/unified_mem_arbiter_pkg.sv | 31 +++
 rtl/unified_mem_arbiter_if.sv | 57 +++++
 rtl/unified_mem_arbiter_timeout_ctr.sv | 47 ++++
 rtl/unified_mem_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory bus arbiter.
// Used by the arbiter, its interface and the core.
package unified_mem_arbiter_pkg;

   localparam int ARB_ADDR_W = 32;
   localparam int ARB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IF_BUSY  = 2'd1,
      MEM_BUSY = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_MEM  = 2'd2
   } arb_owner_t;

   function automatic arb_owner_t arb_owner(arb_state_t s);
      arb_owner_t o;
      o = OWN_NONE;
      unique case (s)
         IF_BUSY:  o = OWN_IF;
         MEM_BUSY: o = OWN_MEM;
         default:  o = OWN_NONE;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Stage-side and bus-side signals of the unified memory arbiter.
// master = arbiter view, slave = stage/memory view.
interface unified_mem_arbiter_if
   import unified_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = ARB_ADDR_W,
   parameter int DATA_W = ARB_DATA_W
) ();

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_flush;
   logic [DATA_W-1:0] if_rdata;
   logic              if_done;
   logic              if_stall;

   logic                mem_req;
   logic                mem_we;
   logic [DATA_W/8-1:0] mem_wstrb;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W-1:0]   mem_rdata;
   logic                mem_done;
   logic                mem_stall;

   logic                bus_req;
   logic                bus_we;
   logic [DATA_W/8-1:0] bus_wstrb;
   logic [ADDR_W-1:0]   bus_addr;
   logic [DATA_W-1:0]   bus_wdata;
   logic                bus_ack;
   logic [DATA_W-1:0]   bus_rdata;
   logic                bus_err;

   modport master (
      input  if_req, if_addr, if_flush,
      output if_rdata, if_done, if_stall,
      input  mem_req, mem_we, mem_wstrb,
      input  mem_addr, mem_wdata,
      output mem_rdata, mem_done, mem_stall,
      output bus_req, bus_we, bus_wstrb,
      output bus_addr, bus_wdata, bus_err,
      input  bus_ack, bus_rdata
   );

   modport slave (
      output if_req, if_addr, if_flush,
      input  if_rdata, if_done, if_stall,
      output mem_req, mem_we, mem_wstrb,
      output mem_addr, mem_wdata,
      input  mem_rdata, mem_done, mem_stall,
      input  bus_req, bus_we, bus_wstrb,
      input  bus_addr, bus_wdata, bus_err,
      output bus_ack, bus_rdata
   );

endinterface

// File: rtl/unified_mem_arbiter_timeout_ctr.sv
// arb_timeout_ctr: clear/load/increment counter, saturating at TERM,
// with a terminal-count flag. Used for bus timeout and perf counters.
module arb_timeout_ctr #(
   parameter int           W    = 8,
   parameter logic [W-1:0] TERM = '1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o,
   output logic         tc_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;
   logic         tc;

   assign tc = (cnt_q == TERM);

   // next count: clear wins, then load, then saturating increment
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (inc_i && !tc) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = tc;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one memory bus between IF and MEM (MEM has priority).
// Optional perf counters are enabled with `define ARB_PERF_CNT_EN.
module unified_mem_arbiter
   import unified_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W         = ARB_ADDR_W,
   parameter int DATA_W         = ARB_DATA_W,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
`ifdef ARB_PERF_CNT_EN
   input  logic        perf_clr,
   output logic [31:0] perf_if_wait,
   output logic [31:0] perf_mem_wait,
   output logic [15:0] perf_if_drop,
`endif
   unified_mem_arbiter_if.master io
);

   localparam int SW    = DATA_W / 8;
   localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
   localparam int TO_W  =
      (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_TERM =
      TO_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

   arb_state_t        state_q, state_d;
   logic              drop_q, drop_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [SW-1:0]     bus_wstrb_q, bus_wstrb_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
   logic              if_done_q, if_done_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic              mem_done_q, mem_done_d;
   logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
   logic              bus_err_q, bus_err_d;

   logic busy;
   logic if_elig;
   logic mem_elig;
   logic to_tc;
   logic abort;
   logic fin;
   logic if_stall;
   logic mem_stall;

   assign busy     = (state_q != IDLE);
   assign mem_elig = io.mem_req & ~mem_done_q;
   assign if_elig  = io.if_req & ~if_done_q & ~io.if_flush;
   assign abort    = TO_EN & busy & ~io.bus_ack & to_tc;
   assign fin      = busy & (io.bus_ack | abort);

   // busy-cycle counter; restarts on every grant
   arb_timeout_ctr #(
      .W    (TO_W),
      .TERM (TO_TERM)
   ) u_to_ctr (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (~busy | io.bus_ack),
      .load_i     (1'b0),
      .load_val_i ('0),
      .inc_i      (busy & ~io.bus_ack),
      .cnt_o      (),
      .tc_o       (to_tc)
   );

   // grant, completion, drop and timeout decisions
   always_comb begin
      state_d     = state_q;
      drop_d      = drop_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_wstrb_d = bus_wstrb_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      if_done_d   = 1'b0;
      mem_done_d  = 1'b0;
      bus_err_d   = 1'b0;
      unique case (arb_owner(state_q))
         OWN_NONE: begin
            if (mem_elig) begin
               state_d     = MEM_BUSY;
               bus_req_d   = 1'b1;
               bus_we_d    = io.mem_we;
               bus_wstrb_d = io.mem_wstrb;
               bus_addr_d  = io.mem_addr;
               bus_wdata_d = io.mem_wdata;
            end else if (if_elig) begin
               state_d     = IF_BUSY;
               bus_req_d   = 1'b1;
               bus_we_d    = 1'b0;
               bus_wstrb_d = '0;
               bus_addr_d  = io.if_addr;
               bus_wdata_d = '0;
            end
         end
         OWN_IF: begin
            if (io.if_flush) begin
               drop_d = 1'b1;
            end
            if (fin) begin
               state_d   = IDLE;
               bus_req_d = 1'b0;
               drop_d    = 1'b0;
               bus_err_d = abort;
               if (!(drop_q || io.if_flush)) begin
                  if_done_d  = 1'b1;
                  if_rdata_d = abort ? '0 : io.bus_rdata;
               end
            end
         end
         OWN_MEM: begin
            if (fin) begin
               state_d     = IDLE;
               bus_req_d   = 1'b0;
               bus_err_d   = abort;
               mem_done_d  = 1'b1;
               mem_rdata_d = (abort || bus_we_q) ? '0 : io.bus_rdata;
            end
         end
         default: begin
            state_d   = IDLE;
            bus_req_d = 1'b0;
            drop_d    = 1'b0;
         end
      endcase
   end

   // state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         drop_q      <= 1'b0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_wstrb_q <= '0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         if_done_q   <= 1'b0;
         if_rdata_q  <= '0;
         mem_done_q  <= 1'b0;
         mem_rdata_q <= '0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         drop_q      <= drop_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_wstrb_q <= bus_wstrb_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         if_done_q   <= if_done_d;
         if_rdata_q  <= if_rdata_d;
         mem_done_q  <= mem_done_d;
         mem_rdata_q <= mem_rdata_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign if_stall  = io.if_req & ~if_done_q & ~io.if_flush;
   assign mem_stall = io.mem_req & ~mem_done_q;

   assign io.if_stall  = if_stall;
   assign io.mem_stall = mem_stall;
   assign io.if_done   = if_done_q;
   assign io.if_rdata  = if_rdata_q;
   assign io.mem_done  = mem_done_q;
   assign io.mem_rdata = mem_rdata_q;
   assign io.bus_req   = bus_req_q;
   assign io.bus_we    = bus_we_q;
   assign io.bus_wstrb = bus_wstrb_q;
   assign io.bus_addr  = bus_addr_q;
   assign io.bus_wdata = bus_wdata_q;
   assign io.bus_err   = bus_err_q;

`ifdef ARB_PERF_CNT_EN
   logic drop_evt;

   assign drop_evt = (state_q == IF_BUSY) & fin &
                     (drop_q | io.if_flush);

   // stall-cycle and dropped-fetch counters
   arb_timeout_ctr #(.W(32)) u_perf_if (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (perf_clr),
      .load_i     (1'b0),
      .load_val_i ('0),
      .inc_i      (if_stall),
      .cnt_o      (perf_if_wait),
      .tc_o       ()
   );

   arb_timeout_ctr #(.W(32)) u_perf_mem (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (perf_clr),
      .load_i     (1'b0),
      .load_val_i ('0),
      .inc_i      (mem_stall),
      .cnt_o      (perf_mem_wait),
      .tc_o       ()
   );

   arb_timeout_ctr #(.W(16)) u_perf_drop (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (perf_clr),
      .load_i     (1'b0),
      .load_val_i ('0),
      .inc_i      (drop_evt),
      .cnt_o      (perf_if_drop),
      .tc_o       ()
   );
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter (TIMEOUT_CYCLES=4).
// Table of single transactions plus hand-written corner sequences.
module tb_unified_mem_arbiter;

   logic clk;
   logic rst_n;

   int checks;
   int failures;

   unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef ARB_PERF_CNT_EN
   logic        perf_clr;
   logic [31:0] perf_if_wait;
   logic [31:0] perf_mem_wait;
   logic [15:0] perf_if_drop;
`endif

   unified_mem_arbiter #(
      .ADDR_W         (32),
      .DATA_W         (32),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
`ifdef ARB_PERF_CNT_EN
      .perf_clr      (perf_clr),
      .perf_if_wait  (perf_if_wait),
      .perf_mem_wait (perf_mem_wait),
      .perf_if_drop  (perf_if_drop),
`endif
      .io            (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          is_mem;
      bit          we;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          dly;
      logic [31:0] brd;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vt[6];

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.if_req    = 1'b0;
      bus.if_addr   = '0;
      bus.if_flush  = 1'b0;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_wstrb = '0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.bus_ack   = 1'b0;
      bus.bus_rdata = '0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      string s;
      s = $sformatf("v%0d", idx);
      @(negedge clk);
      if (v.is_mem) begin
         bus.mem_req   = 1'b1;
         bus.mem_we    = v.we;
         bus.mem_wstrb = v.wstrb;
         bus.mem_addr  = v.addr;
         bus.mem_wdata = v.wdata;
      end else begin
         bus.if_req  = 1'b1;
         bus.if_addr = v.addr;
      end
      #1;
      chk({s, ".stall_req"},
          v.is_mem ? bus.mem_stall : bus.if_stall, 1);
      @(negedge clk);
      chk({s, ".bus_req"}, bus.bus_req, 1);
      chk({s, ".bus_addr"}, bus.bus_addr, v.addr);
      chk({s, ".bus_we"}, bus.bus_we, v.is_mem ? v.we : 1'b0);
      chk({s, ".bus_wstrb"}, bus.bus_wstrb,
          v.is_mem ? v.wstrb : 4'h0);
      chk({s, ".bus_wdata"}, bus.bus_wdata,
          v.is_mem ? v.wdata : 32'h0);
      repeat (v.dly) @(negedge clk);
      bus.bus_ack   = 1'b1;
      bus.bus_rdata = v.brd;
      @(negedge clk);
      bus.bus_ack   = 1'b0;
      bus.bus_rdata = '0;
      chk({s, ".done"},
          v.is_mem ? bus.mem_done : bus.if_done, 1);
      chk({s, ".rdata"},
          v.is_mem ? bus.mem_rdata : bus.if_rdata, v.exp_rd);
      chk({s, ".bus_req_off"}, bus.bus_req, 0);
      chk({s, ".bus_err"}, bus.bus_err, 0);
      chk({s, ".stall_done"},
          v.is_mem ? bus.mem_stall : bus.if_stall, 0);
      bus.if_req  = 1'b0;
      bus.mem_req = 1'b0;
      @(negedge clk);
      chk({s, ".done_pulse"},
          v.is_mem ? bus.mem_done : bus.if_done, 0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      vt[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0,
                3, 32'h0000_0013, 32'h0000_0013};
      vt[1] = '{1'b1, 1'b0, 4'h0, 32'h0000_2000, 32'h0,
                0, 32'hCAFE_F00D, 32'hCAFE_F00D};
      vt[2] = '{1'b1, 1'b1, 4'h3, 32'h0000_2004, 32'h1234_5678,
                1, 32'hFFFF_FFFF, 32'h0};
      vt[3] = '{1'b0, 1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0,
                2, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
      vt[4] = '{1'b1, 1'b1, 4'hF, 32'h0000_2000, 32'hDEAD_BEEF,
                2, 32'h0000_0055, 32'h0};
      vt[5] = '{1'b1, 1'b0, 4'h0, 32'h0000_2008, 32'h0,
                1, 32'h1122_3344, 32'h1122_3344};

`ifdef ARB_PERF_CNT_EN
      perf_clr = 1'b0;
`endif
      idle_inputs();
      rst_n = 1'b0;

      // reset state
      @(negedge clk);
      chk("rst.bus_req", bus.bus_req, 0);
      chk("rst.bus_addr", bus.bus_addr, 0);
      chk("rst.if_done", bus.if_done, 0);
      chk("rst.mem_done", bus.mem_done, 0);
      chk("rst.bus_err", bus.bus_err, 0);
      chk("rst.if_stall", bus.if_stall, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         run_vec(vt[i], i);
      end

      // simultaneous requests: MEM first, IF right after mem_done
      @(negedge clk);
      bus.if_req    = 1'b1;
      bus.if_addr   = 32'h0000_0300;
      bus.mem_req   = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_wstrb = 4'hF;
      bus.mem_addr  = 32'h0000_2000;
      bus.mem_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("pri.bus_we", bus.bus_we, 1);
      chk("pri.bus_addr", bus.bus_addr, 32'h2000);
      chk("pri.bus_wdata", bus.bus_wdata, 32'hDEAD_BEEF);
      chk("pri.if_stall", bus.if_stall, 1);
      bus.bus_ack   = 1'b1;
      bus.bus_rdata = 32'h0000_0099;
      @(negedge clk);
      bus.bus_ack = 1'b0;
      chk("pri.mem_done", bus.mem_done, 1);
      chk("pri.mem_rdata", bus.mem_rdata, 0);
      chk("pri.if_done", bus.if_done, 0);
      chk("pri.bus_req_off", bus.bus_req, 0);
      @(negedge clk);
      bus.mem_req = 1'b0;
      chk("pri.if_grant", bus.bus_req, 1);
      chk("pri.if_addr", bus.bus_addr, 32'h300);
      chk("pri.if_we", bus.bus_we, 0);
      bus.bus_ack   = 1'b1;
      bus.bus_rdata = 32'h0000_0044;
      @(negedge clk);
      bus.bus_ack = 1'b0;
      chk("pri.if_done", bus.if_done, 1);
      chk("pri.if_rdata", bus.if_rdata, 32'h44);
      bus.if_req = 1'b0;
      @(negedge clk);

      // if_req held across the done cycle
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h0000_0400;
      @(negedge clk);
      chk("hold.grant1", bus.bus_req, 1);
      bus.bus_ack   = 1'b1;
      bus.bus_rdata = 32'h1111_0000;
      @(negedge clk);
      bus.bus_ack = 1'b0;
      chk("hold.done1", bus.if_done, 1);
      chk("hold.rdata1", bus.if_rdata, 32'h1111_0000);
      @(negedge clk);
      chk("hold.no_regrant", bus.bus_req, 0);
      chk("hold.done_low", bus.if_done, 0);
      chk("hold.stall", bus.if_stall, 1);
      @(negedge clk);
      chk("hold.grant2", bus.bus_req, 1);
      chk("hold.addr2", bus.bus_addr, 32'h400);
      bus.bus_ack   = 1'b1;
      bus.bus_rdata = 32'h2222_0000;
      @(negedge clk);
      bus.bus_ack = 1'b0;
      chk("hold.done2", bus.if_done, 1);
      chk("hold.rdata2", bus.if_rdata, 32'h2222_0000);
      bus.if_req = 1'b0;
      @(negedge clk);

      // flush during IF_BUSY, re-issued fetch waits for dropped ack
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h0000_0500;
      @(negedge clk);
      chk("fl.grant", bus.bus_addr, 32'h500);
      bus.if_flush = 1'b1;
      #1;
      chk("fl.stall_flush", bus.if_stall, 0);
      @(negedge clk);
      bus.if_flush = 1'b0;
      bus.if_addr  = 32'h0000_0200;
      #1;
      chk("fl.stall_reissue", bus.if_stall, 1);
      chk("fl.frozen_addr", bus.bus_addr, 32'h500);
      @(negedge clk);
      chk("fl.no_regrant", bus.bus_addr, 32'h500);
      chk("fl.bus_req", bus.bus_req, 1);
      bus.bus_ack   = 1'b1;
      bus.bus_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      bus.bus_ack = 1'b0;
      chk("fl.no_done", bus.if_done, 0);
      chk("fl.rdata_kept", bus.if_rdata, 32'h2222_0000);
      chk("fl.bus_req_off", bus.bus_req, 0);
      chk("fl.stall_held", bus.if_stall, 1);
      @(negedge clk);
      chk("fl.regrant", bus.bus_req, 1);
      chk("fl.regrant_addr", bus.bus_addr, 32'h200);
      bus.bus_ack   = 1'b1;
      bus.bus_rdata = 32'h0000_0297;
      @(negedge clk);
      bus.bus_ack = 1'b0;
      chk("fl.done", bus.if_done, 1);
      chk("fl.rdata", bus.if_rdata, 32'h297);
      bus.if_req = 1'b0;
      @(negedge clk);

      // load with no ack: timeout after 4 busy cycles
      bus.mem_req  = 1'b1;
      bus.mem_we   = 1'b0;
      bus.mem_addr = 32'h0000_3000;
      @(negedge clk);
      chk("to.grant", bus.bus_req, 1);
      repeat (3) @(negedge clk);
      chk("to.still_busy", bus.bus_req, 1);
      chk("to.no_err_yet", bus.bus_err, 0);
      chk("to.no_done_yet", bus.mem_done, 0);
      @(negedge clk);
      chk("to.bus_err", bus.bus_err, 1);
      chk("to.mem_done", bus.mem_done, 1);
      chk("to.mem_rdata", bus.mem_rdata, 0);
      chk("to.bus_req_off", bus.bus_req, 0);
      bus.mem_req   = 1'b0;
      bus.bus_ack   = 1'b1;
      bus.bus_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      bus.bus_ack = 1'b0;
      chk("to.err_pulse", bus.bus_err, 0);
      chk("to.late_done", bus.mem_done, 0);
      chk("to.late_rdata", bus.mem_rdata, 0);
      chk("to.late_req", bus.bus_req, 0);
      chk("to.late_if", bus.if_done, 0);

      // reset in MEM_BUSY
      @(negedge clk);
      bus.mem_req   = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_wstrb = 4'hF;
      bus.mem_addr  = 32'h0000_4000;
      bus.mem_wdata = 32'h0BAD_F00D;
      @(negedge clk);
      chk("rs.grant", bus.bus_addr, 32'h4000);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rs.bus_req", bus.bus_req, 0);
      chk("rs.bus_addr", bus.bus_addr, 0);
      chk("rs.bus_we", bus.bus_we, 0);
      chk("rs.bus_wdata", bus.bus_wdata, 0);
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rs.idle_req", bus.bus_req, 0);
      chk("rs.idle_done", bus.mem_done, 0);
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h0000_0700;
      @(negedge clk);
      chk("rs.if_grant", bus.bus_req, 1);
      chk("rs.if_addr", bus.bus_addr, 32'h700);
      bus.bus_ack   = 1'b1;
      bus.bus_rdata = 32'h0000_0013;
      @(negedge clk);
      bus.bus_ack = 1'b0;
      chk("rs.if_done", bus.if_done, 1);
      chk("rs.if_rdata", bus.if_rdata, 32'h13);
      bus.if_req = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
